sdft_bin_update_pipe: RTL

- Next-generation sliding-DFT bin update engine.
- Computes Xk_new = twiddle * (Xk_prev + sample_diff) for one bin per accepted beat.
- Has a ready/valid handshake with full backpressure, rounding and saturation, a parametrised multiplier latency, and frame tracking.
- Sits between the bin-memory read port and the bin-memory write-back and display path of the STFT block.

---
 rtl/sdft_bin_update_pipe.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/sdft_bin_update_pipe.sv
// Sliding-DFT bin update: Xk_new = twiddle * (Xk_prev + sample_diff), one bin per beat,
// with a stall-all valid/ready pipeline, rounding/saturation and frame counting.
module sdft_bin_update_pipe #(
    parameter int WORD_WIDTH   = 16,
    parameter int FFT_SIZE     = 512,
    parameter int FRAC_BITS    = 15,
    parameter int MULT_LATENCY = 3,
    parameter int SAT_EN       = 1,
    localparam int IDX_W       = $clog2(FFT_SIZE)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_valid,
    output logic                    o_in_ready,
    input  logic [WORD_WIDTH-1:0]   i_sample_diff,
    input  logic [2*WORD_WIDTH-1:0] i_twiddle,
    input  logic [2*WORD_WIDTH-1:0] i_xk_prev,
    input  logic [IDX_W-1:0]        i_idx,
    input  logic                    i_wr_en,
    input  logic                    i_last,
    output logic                    o_valid,
    input  logic                    i_out_ready,
    output logic [2*WORD_WIDTH-1:0] o_xk,
    output logic [IDX_W-1:0]        o_idx,
    output logic                    o_wr_en,
    output logic                    o_last,
    output logic                    o_sat,
    output logic                    o_frame_done,
    output logic [15:0]             o_frame_count
);

    localparam int W      = WORD_WIDTH;
    localparam int ML     = MULT_LATENCY;
    localparam int FULL_W = 2 * W + 2;
    localparam int SB_W   = IDX_W + 2;

    localparam logic signed [FULL_W-1:0] RND   = FULL_W'(longint'(1) << (FRAC_BITS - 1));
    localparam logic signed [FULL_W-1:0] MAX_V = FULL_W'((longint'(1) << (W - 1)) - 1);
    localparam logic signed [FULL_W-1:0] MIN_V = ~MAX_V;

    // Valid/ready: a beat moves on a cycle where valid && ready are both high at the rising
    // edge. The whole pipe advances together unless the output beat is held (o_valid && !i_out_ready).
    logic stall;
    logic adv;

    // Stage 0: pre-add result plus operands and sideband {idx, wr_en, last}
    logic                v0_q, v0_d;
    logic [W:0]          pre_re0_q, pre_re0_d;
    logic [W-1:0]        im0_q, im0_d;
    logic [W-1:0]        c0_q, c0_d;
    logic [W-1:0]        d0_q, d0_d;
    logic [SB_W-1:0]     sb0_q, sb0_d;

    // Stages 1..ML: stage 1 holds the rounded result; later stages are delay for retiming
    logic [ML-1:0]                 st_v_q, st_v_d;
    logic [ML-1:0][2*W-1:0]        st_xk_q, st_xk_d;
    logic [ML-1:0]                 st_sat_q, st_sat_d;
    logic [ML-1:0][SB_W-1:0]       st_sb_q, st_sb_d;

    logic        fd_q, fd_d;
    logic [15:0] fc_q, fc_d;

    logic signed [FULL_W-1:0] pre_x, im_x, c_x, d_x;
    logic signed [FULL_W-1:0] re_full, im_full;
    logic [W:0]               re_cs, im_cs;

    // Returns {clamped, value}: round half-up, then clamp or wrap to W bits
    function automatic logic [W:0] round_clamp(input logic signed [FULL_W-1:0] v);
        logic signed [FULL_W-1:0] r;
        r = (v + RND) >>> FRAC_BITS;
        if (SAT_EN != 0) begin
            if (r > MAX_V) begin
                return {1'b1, MAX_V[W-1:0]};
            end else if (r < MIN_V) begin
                return {1'b1, MIN_V[W-1:0]};
            end
        end
        return {1'b0, r[W-1:0]};
    endfunction

    always_comb begin
        stall = st_v_q[ML-1] && !i_out_ready;
        adv   = !stall;

        pre_x   = FULL_W'($signed(pre_re0_q));
        im_x    = FULL_W'($signed(im0_q));
        c_x     = FULL_W'($signed(c0_q));
        d_x     = FULL_W'($signed(d0_q));
        re_full = pre_x * c_x - im_x * d_x;
        im_full = pre_x * d_x + im_x * c_x;
        re_cs   = round_clamp(re_full);
        im_cs   = round_clamp(im_full);

        v0_d      = v0_q;
        pre_re0_d = pre_re0_q;
        im0_d     = im0_q;
        c0_d      = c0_q;
        d0_d      = d0_q;
        sb0_d     = sb0_q;
        st_v_d    = st_v_q;
        st_xk_d   = st_xk_q;
        st_sat_d  = st_sat_q;
        st_sb_d   = st_sb_q;

        if (adv) begin
            v0_d      = i_valid;
            pre_re0_d = {i_xk_prev[2*W-1], i_xk_prev[2*W-1:W]} + {i_sample_diff[W-1], i_sample_diff};
            im0_d     = i_xk_prev[W-1:0];
            c0_d      = i_twiddle[2*W-1:W];
            d0_d      = i_twiddle[W-1:0];
            sb0_d     = {i_idx, i_wr_en, i_last};

            st_v_d[0]   = v0_q;
            st_xk_d[0]  = {re_cs[W-1:0], im_cs[W-1:0]};
            st_sat_d[0] = re_cs[W] | im_cs[W];
            st_sb_d[0]  = sb0_q;
            for (int k = 1; k < ML; k++) begin
                st_v_d[k]   = st_v_q[k-1];
                st_xk_d[k]  = st_xk_q[k-1];
                st_sat_d[k] = st_sat_q[k-1];
                st_sb_d[k]  = st_sb_q[k-1];
            end
        end

        // Frame completes only on an accepted last beat; pulse lands the following cycle
        fd_d = st_v_q[ML-1] && i_out_ready && st_sb_q[ML-1][0];
        fc_d = fc_q + 16'(fd_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v0_q      <= 1'b0;
            pre_re0_q <= '0;
            im0_q     <= '0;
            c0_q      <= '0;
            d0_q      <= '0;
            sb0_q     <= '0;
            st_v_q    <= '0;
            st_xk_q   <= '0;
            st_sat_q  <= '0;
            st_sb_q   <= '0;
            fd_q      <= 1'b0;
            fc_q      <= '0;
        end else begin
            v0_q      <= v0_d;
            pre_re0_q <= pre_re0_d;
            im0_q     <= im0_d;
            c0_q      <= c0_d;
            d0_q      <= d0_d;
            sb0_q     <= sb0_d;
            st_v_q    <= st_v_d;
            st_xk_q   <= st_xk_d;
            st_sat_q  <= st_sat_d;
            st_sb_q   <= st_sb_d;
            fd_q      <= fd_d;
            fc_q      <= fc_d;
        end
    end

    assign o_in_ready    = !stall;
    assign o_valid       = st_v_q[ML-1];
    assign o_xk          = st_xk_q[ML-1];
    assign o_sat         = st_sat_q[ML-1];
    assign o_idx         = st_sb_q[ML-1][SB_W-1:2];
    assign o_wr_en       = st_sb_q[ML-1][1];
    assign o_last        = st_sb_q[ML-1][0];
    assign o_frame_done  = fd_q;
    assign o_frame_count = fc_q;

endmodule
